// File: rtl/inv_mixcol_engine_pkg.sv
// Shared constants, FSM state type and the xtime helper for the AES
// InvMixColumns engine.
//   AES_POLY_RED  - low byte of the reduction polynomial 0x11B
//   INV_COEF_*    - InvMixColumns matrix coefficients
//   STATE_W/COL_W - widths of a full AES state and of one column
//   eng_state_t   - engine FSM states
//   xtime()       - multiply by x (i.e. by 2) in GF(2^8)
package aes_pkg;

   localparam int STATE_W = 128;
   localparam int COL_W   = 32;

   localparam logic [7:0] AES_POLY_RED = 8'h1B;
   localparam logic [7:0] INV_COEF_E   = 8'h0E;
   localparam logic [7:0] INV_COEF_B   = 8'h0B;
   localparam logic [7:0] INV_COEF_D   = 8'h0D;
   localparam logic [7:0] INV_COEF_9   = 8'h09;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } eng_state_t;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY_RED : 8'h00);
   endfunction

endpackage

// File: rtl/inv_mixcol_engine_if.sv
// Handshake bundle between the InvMixColumns engine and its environment.
//   in_valid/in_ready/in_state    - state offered to the engine
//   out_valid/out_ready/out_state - transformed state returned
// master: environment side (producer of in_*, consumer of out_*)
// slave : engine side
interface inv_mixcol_engine_if;
   import aes_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [STATE_W-1:0] in_state;
   logic               out_valid;
   logic               out_ready;
   logic [STATE_W-1:0] out_state;

   modport master (
      output in_valid, in_state, out_ready,
      input  in_ready, out_valid, out_state
   );

   modport slave (
      input  in_valid, in_state, out_ready,
      output in_ready, out_valid, out_state
   );

endinterface

// File: rtl/inv_mixcol_engine_col32.sv
// Combinational InvMixColumns of a single 32-bit column.
//   col_in  - column a, row0 byte in bits [31:24]
//   col_out - column b = M*a over GF(2^8), same byte layout
// All multiplies are composed from xtime; no generic multiplier.
module inv_mix_col32
   import aes_pkg::*;
(
   input  logic [COL_W-1:0] col_in,
   output logic [COL_W-1:0] col_out
);

   function automatic logic [7:0] gmul_inv(input logic [7:0] x, input logic [7:0] coef);
      logic [7:0] x2, x4, x8;
      x2 = xtime(x);
      x4 = xtime(x2);
      x8 = xtime(x4);
      case (coef)
         INV_COEF_9: return x8 ^ x;
         INV_COEF_B: return x8 ^ x2 ^ x;
         INV_COEF_D: return x8 ^ x4 ^ x;
         default:    return x8 ^ x4 ^ x2;
      endcase
   endfunction

   logic [7:0] a0, a1, a2, a3;
   logic [7:0] b0, b1, b2, b3;

   assign {a0, a1, a2, a3} = col_in;

   assign b0 = gmul_inv(a0, INV_COEF_E) ^ gmul_inv(a1, INV_COEF_B)
             ^ gmul_inv(a2, INV_COEF_D) ^ gmul_inv(a3, INV_COEF_9);
   assign b1 = gmul_inv(a0, INV_COEF_9) ^ gmul_inv(a1, INV_COEF_E)
             ^ gmul_inv(a2, INV_COEF_B) ^ gmul_inv(a3, INV_COEF_D);
   assign b2 = gmul_inv(a0, INV_COEF_D) ^ gmul_inv(a1, INV_COEF_9)
             ^ gmul_inv(a2, INV_COEF_E) ^ gmul_inv(a3, INV_COEF_B);
   assign b3 = gmul_inv(a0, INV_COEF_B) ^ gmul_inv(a1, INV_COEF_D)
             ^ gmul_inv(a2, INV_COEF_9) ^ gmul_inv(a3, INV_COEF_E);

   assign col_out = {b0, b1, b2, b3};

endmodule

// File: rtl/inv_mixcol_engine.sv
// Iterative AES InvMixColumns engine: one column per cycle through a
// single shared column unit, result held until the consumer takes it.
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - handshake bundle (slave side): in_valid/in_ready/in_state,
//         out_valid/out_ready/out_state
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a state; in_ready=1
// BUSY  | transforming column col_cnt in place, four cycles total
// DONE  | result on out_state; in_ready follows out_ready so a new
//       | state can be taken in the same cycle the result leaves
module inv_mixcol_engine
   import aes_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   inv_mixcol_engine_if.slave bus
);

   eng_state_t         state_q, state_d;
   logic [1:0]         col_cnt_q;
   logic [STATE_W-1:0] work_q, work_d;
   logic [COL_W-1:0]   col_in, col_out;
   logic               load, step;
   logic               in_ready, out_valid;

   inv_mix_col32 u_col (
      .col_in  (col_in),
      .col_out (col_out)
   );

   always_comb begin
      col_in = work_q[127:96];
      case (col_cnt_q)
         2'd1:    col_in = work_q[95:64];
         2'd2:    col_in = work_q[63:32];
         2'd3:    col_in = work_q[31:0];
         default: col_in = work_q[127:96];
      endcase
   end

   always_comb begin
      work_d = work_q;
      case (col_cnt_q)
         2'd1:    work_d[95:64]  = col_out;
         2'd2:    work_d[63:32]  = col_out;
         2'd3:    work_d[31:0]   = col_out;
         default: work_d[127:96] = col_out;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               load    = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            step = 1'b1;
            if (col_cnt_q == 2'd3) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = bus.out_ready;
            if (bus.out_ready) begin
               if (bus.in_valid) begin
                  load    = 1'b1;
                  state_d = BUSY;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // col_cnt parks at 3 after the last column; only a new capture clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         col_cnt_q <= 2'd0;
         work_q    <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            work_q    <= bus.in_state;
            col_cnt_q <= 2'd0;
         end else if (step) begin
            work_q <= work_d;
            if (col_cnt_q != 2'd3) col_cnt_q <= col_cnt_q + 2'd1;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_state = work_q;

endmodule

// File: tb/tb_inv_mixcol_engine.sv
// Scoreboard bench for inv_mixcol_engine. Expected results are queued at
// acceptance and popped by a negedge monitor on each output transfer.
module tb_inv_mixcol_engine;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   inv_mixcol_engine_if bus ();

   inv_mixcol_engine dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [127:0] exp_q[$];
   int           xfer_q[$];
   logic [127:0] pend_exp;
   int           acc_cyc = 0;
   logic         prev_ov = 1'b0;

   // ---------------- reference model (forward MixColumns) ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [127:0] fwd_mix(input logic [127:0] s);
      logic [7:0]   a[4];
      logic [7:0]   coef[4];
      logic [7:0]   acc;
      logic [127:0] r = '0;
      coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - row + 4) % 4], a[k]);
            r[127 - 32*c - 8*row -: 8] = acc;
         end
      end
      return r;
   endfunction

   // ---------------- checks ----------------
   task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (bus.out_valid && !prev_ov) chk_int("latency", cyc - acc_cyc, 4);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_output: got %h expected none", bus.out_state);
            end else begin
               chk128("out_state", bus.out_state, exp_q.pop_front());
            end
            xfer_q.push_back(cyc);
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(pend_exp);
            acc_cyc = cyc + 1;
         end
      end
      prev_ov = bus.out_valid;
   end

   // ---------------- driver helpers (called at posedge+1) ----------------
   task automatic send(input logic [127:0] st, input logic [127:0] exp, input bit keep);
      int w = 0;
      bus.in_valid = 1'b1;
      bus.in_state = st;
      pend_exp     = exp;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         @(posedge clk);
         #1;
         w++;
         if (w > 2) bus.out_ready = 1'b1;
         if (w > 50) begin
            chk_int("send_timeout", w, 0);
            break;
         end
      end
      @(posedge clk);
      #1;
      if (!keep) bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      bus.out_ready = 1'b1;
      while (exp_q.size() != 0 && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk_int("drain_left", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   localparam logic [127:0] V_SINGLE_IN  = {4{32'h8e4da1bc}};
   localparam logic [127:0] V_SINGLE_OUT = {4{32'hdb135345}};
   localparam logic [127:0] V_MIX_IN  = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6};
   localparam logic [127:0] V_MIX_OUT = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5};
   localparam logic [127:0] V_C6      = {4{32'hc6c6c6c6}};
   localparam logic [127:0] V_4D_IN   = {4{32'h4d7ebdf8}};
   localparam logic [127:0] V_4D_OUT  = {4{32'h2d26314c}};

   initial begin
      logic [127:0] st;
      int w;
      int n0;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_state  = '0;
      bus.out_ready = 1'b1;
      pend_exp      = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_int("rst_in_ready", int'(bus.in_ready), 1);
      chk_int("rst_out_valid", int'(bus.out_valid), 0);
      chk128("rst_out_state", bus.out_state, '0);
      @(posedge clk);
      #1;

      // single-column vector, then mixed state
      send(V_SINGLE_IN, V_SINGLE_OUT, 0);
      drain();
      send(V_MIX_IN, V_MIX_OUT, 0);
      drain();

      // backpressure in DONE
      bus.out_ready = 1'b0;
      send(V_SINGLE_IN, V_SINGLE_OUT, 0);
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!bus.out_valid && w < 20);
      chk_int("bp_reach_done", int'(bus.out_valid), 1);
      @(posedge clk);
      #1;
      n0 = xfer_q.size();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk128("bp_hold_state", bus.out_state, V_SINGLE_OUT);
         chk_int("bp_in_ready", int'(bus.in_ready), 0);
         chk_int("bp_out_valid", int'(bus.out_valid), 1);
         @(posedge clk);
         #1;
         if (i == 3) begin
            bus.in_valid = 1'b1;
            bus.in_state = V_MIX_IN;
         end
         if (i == 7) bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk_int("bp_single_xfer", xfer_q.size() - n0, 1);
      chk_int("bp_idle_out_valid", int'(bus.out_valid), 0);
      chk_int("bp_no_capture", exp_q.size(), 0);
      @(posedge clk);
      #1;

      // back-to-back: in_valid and out_ready held high
      xfer_q.delete();
      for (int i = 0; i < 4; i++) send(V_C6, V_C6, 1);
      for (int i = 0; i < 4; i++) send(V_4D_IN, V_4D_OUT, 1);
      bus.in_valid = 1'b0;
      drain();
      chk_int("b2b_count", xfer_q.size(), 8);
      for (int i = 1; i < xfer_q.size(); i++)
         chk_int("b2b_period", xfer_q[i] - xfer_q[i-1], 5);

      // reset mid-BUSY
      send(V_MIX_IN, V_MIX_OUT, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_int("midrst_in_ready", int'(bus.in_ready), 1);
      chk_int("midrst_out_valid", int'(bus.out_valid), 0);
      chk128("midrst_work_clear", bus.out_state, '0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk_int("midrst_no_output", int'(bus.out_valid), 0);
      end
      @(posedge clk);
      #1;
      send(V_MIX_IN, V_MIX_OUT, 0);
      drain();

      // round trip: forward model then engine must restore the original
      for (int i = 0; i < 1000; i++) begin
         st = {$urandom, $urandom, $urandom, $urandom};
         bus.out_ready = ($urandom_range(0, 3) != 0);
         send(fwd_mix(st), st, $urandom_range(0, 1) == 1);
      end
      bus.in_valid = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/inv_mixcol_engine.md
INV_MIXCOL_ENGINE -- requirements
Module: inv_mixcol_engine

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 SHALL expose: clk  input  1  rising-edge clock (listed first).
REQ-003 SHALL expose: rst  input  1  synchronous active-high reset.
REQ-004 SHALL expose: in_valid  input  1  in_state carries a valid 128-bit AES state.
REQ-005 SHALL expose: in_ready  output  1  engine accepts in_state this cycle.
REQ-006 SHALL expose: in_state  input  128  state to transform; column c = bits [127-32c -: 32]; row0 byte = column MSB byte.
REQ-007 SHALL expose: out_valid  output  1  out_state holds a complete result.
REQ-008 SHALL expose: out_ready  input  1  consumer takes out_state this cycle.
REQ-009 SHALL expose: out_state  output  128  InvMixColumns(in_state); same column/byte layout as in_state.

Function
REQ-010 SHALL compute per column b = M·a over GF(2^8), reduction polynomial 0x11B; M rows = {0e 0b 0d 09}, {09 0e 0b 0d}, {0d 09 0e 0b}, {0b 0d 09 0e}.
REQ-011 SHALL build multiplies from xtime only: xtime(x) = (x<<1)[7:0] ^ (x[7] ? 0x1B : 0x00); x9 = x8^x; xB = x8^x2^x; xD = x8^x4^x; xE = x8^x4^x2.
REQ-012 SHALL use FSM states IDLE, BUSY, DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; in_valid=1 -> capture in_state into the working register, clear col_cnt to 0, go BUSY.
REQ-014 BUSY: in_ready=0, out_valid=0; each cycle transform column col_cnt in place, increment 2-bit col_cnt; after column 3, go DONE.
REQ-015 DONE: out_valid=1; out_state = working register, held stable while out_ready=0.
REQ-016 DONE with out_ready=1 and in_valid=0 -> go IDLE.
REQ-017 DONE with out_ready=1 SHALL drive in_ready=1 combinationally from out_ready; with in_valid=1 also asserted, capture the new state, clear col_cnt, go BUSY (back-to-back, no bubble).
REQ-018 DONE with out_ready=0 SHALL drive in_ready=0; in_valid is ignored.
REQ-019 Latency SHALL be fixed: input accepted at edge T -> out_valid=1 after edge T+4; throughput one state per 5 cycles under continuous ready.
REQ-020 in_valid asserted in BUSY SHALL be ignored; no input is lost because in_ready=0.
REQ-021 col_cnt SHALL wrap 3 -> 0 only via a new capture; it never advances outside BUSY.
REQ-022 out_state SHALL equal the working register in all states; its value is meaningful only when out_valid=1.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, col_cnt=0, working register=0, out_valid=0, in_ready=1 after that edge, regardless of state.
REQ-024 Reset mid-BUSY or in DONE SHALL discard the partial or pending result; no out_valid pulse follows.
REQ-025 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-026 Package aes_pkg SHALL hold: AES_POLY_RED = 8'h1B, InvMixColumns coefficients (8'h0E, 8'h0B, 8'h0D, 8'h09), state/column width constants, and FSM state enum type.
REQ-027 Column arithmetic SHALL live in one combinational sub-module inv_mix_col32 (32-bit in, 32-bit out), instantiated once and muxed by col_cnt.
REQ-028 The engine SHALL contain no other arithmetic; sequencing and handshake only.

Verification
REQ-029 Single column vector: state with every column 8e4da1bc -> every output column db135345, out_valid exactly 4 cycles after acceptance.
REQ-030 Mixed state: columns {8e4da1bc, 9fdc589d, 01010101, d5d5d7d6} -> {db135345, f20a225c, 01010101, d4d4d4d5}.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_state stable, in_ready=0, late in_valid not captured; release -> single transfer.
REQ-032 Back-to-back: in_valid=1 and out_ready=1 continuously, states c6c6c6c6 x4 then 4d7ebdf8 x4 -> outputs c6c6c6c6 x4 then 2d26314c x4, one result per 5 cycles.
REQ-033 Reset mid-operation: assert rst after 2 BUSY cycles -> next cycle IDLE, in_ready=1, out_valid=0, no result emitted; next input processes correctly.
REQ-034 Round-trip: random states through forward MixColumns model, then this engine -> output equals original state for 1000 vectors.
